benes_pipe_network: RTL and testbench
=====================================

BENES_PIPE_NETWORK -- requirements
Module: benes_pipe_network

Interface
REQ-001 Parameter: SIZE, default 16, port count; power of two, >=4.
REQ-002 Parameter: DATA_WIDTH, default 512, bits per port.
REQ-003 Derived constants: LOG_N = log2(SIZE); STAGE_NUM = 2*LOG_N-1; SWITCH_NUM = SIZE/2.
REQ-004 Port: clk  in  1  single clock, all logic rising-edge.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: i_valid  in  1  input beat valid.
REQ-007 Port: o_in_ready  out  1  beat accepted when i_valid && o_in_ready.
REQ-008 Port: i_port  in  DATA_WIDTH x SIZE  input beat.
REQ-009 Port: o_valid  out  1  output beat valid.
REQ-010 Port: i_out_ready  in  1  downstream accepts output.
REQ-011 Port: o_port  out  DATA_WIDTH x SIZE  routed beat.
REQ-012 Port: cfg_we  in  1  write one stage row into the shadow bank.
REQ-013 Port: cfg_stage  in  clog2(STAGE_NUM)  row index; values >= STAGE_NUM ignored.
REQ-014 Port: cfg_bits  in  SWITCH_NUM  switch controls for that row.
REQ-015 Port: cfg_commit  in  1  swap shadow and active banks.
REQ-016 Port: o_cfg_ready  out  1  shadow bank writable.

Function
REQ-017 Switch k of any stage: bit 0 = straight (2k->2k, 2k+1->2k+1); bit 1 = cross.
REQ-018 Wiring after stage s, s < LOG_N-1: inverse perfect shuffle within blocks of size SIZE>>s (even outputs to lower half, odd to upper half).
REQ-019 Wiring after stage s, s >= LOG_N-1: mirror of REQ-018 (perfect shuffle), making the network a standard Benes.
REQ-020 One register per stage; latency is exactly STAGE_NUM cycles from acceptance to o_valid with no stall.
REQ-021 Each accepted beat carries the active-bank ID sampled at acceptance; every stage uses that bank's row, not the current active bank.
REQ-022 Global stall = o_valid && !i_out_ready; during a stall all stage registers hold; o_in_ready = !stall.
REQ-023 Bubbles (valid=0) propagate; o_port is don't-care when o_valid=0.
REQ-024 cfg_we writes are accepted only when o_cfg_ready=1; otherwise dropped.
REQ-025 cfg_commit toggles the active bank at the next edge, unconditionally.
REQ-026 Write and commit in the same cycle: the write lands in the pre-swap shadow bank and becomes active.
REQ-027 Beat accepted in the same cycle as commit uses the pre-swap active bank.
REQ-028 Per-bank in-flight counter, width clog2(STAGE_NUM+1): +1 on acceptance, -1 on output handshake; simultaneous +1/-1 on the same bank leaves it unchanged.
REQ-029 o_cfg_ready = (in-flight count of shadow bank == 0).

Reset
REQ-030 rst_n low: all stage valids 0, o_valid 0, both counters 0, active bank 0, both banks all-zero (all straight).
REQ-031 o_in_ready = 1 and o_cfg_ready = 1 from the first cycle after reset release.
REQ-032 Reset mid-operation discards in-flight beats; no partial output.

Configuration
REQ-033 Macro BENES_BYPASS_EN: when defined, adds input port i_bypass (1 bit), carried per beat; bypass beats route as if all switches were 0 and do not increment any bank counter.
REQ-034 Without BENES_BYPASS_EN: no i_bypass port; all beats use the banked configuration.

Structure
REQ-035 Shared package benes_pkg: SIZE/DATA_WIDTH defaults, derived constants, bank-ID typedef, and a function giving the inter-stage port permutation.
REQ-036 Sub-module benes_stage: SWITCH_NUM 2x2 switches plus a stall-gated output register.

Verification
REQ-037 SIZE=8: all banks zero; beat i_port[p]=p -> o_port[p]=p after 5 cycles.
REQ-038 SIZE=8: all rows all-ones -> output equals the permutation computed by the reference model; random rows checked against the model over 1000 beats.
REQ-039 Stream 10 beats, hold i_out_ready=0 for 4 cycles -> no loss or duplication, order preserved, o_in_ready=0 during the stall.
REQ-040 Program bank B1 with a reversal, commit while 3 bank-0 beats are in flight -> those beats routed identity, later beats reversed, o_cfg_ready=0 until the third beat leaves.
REQ-041 Assert rst_n low with 4 beats in flight -> o_valid=0 immediately and no beats emerge after release.
REQ-042 With BENES_BYPASS_EN: bypass beat under a non-zero config -> identity output, counters unchanged.

Source files
------------

// File: rtl/benes_pkg.sv
// Shared constants, bank-ID type and inter-stage wiring function for the
// pipelined Benes permutation network.
package benes_pkg;

  localparam int DEF_SIZE       = 16;
  localparam int DEF_DATA_WIDTH = 512;
  localparam int DEF_LOG_N      = $clog2(DEF_SIZE);
  localparam int DEF_STAGE_NUM  = 2 * DEF_LOG_N - 1;
  localparam int DEF_SWITCH_NUM = DEF_SIZE / 2;

  // Two configuration banks: one active, one shadow.
  typedef logic bank_id_t;

  // Destination input port of stage s+1 for output port p of stage s.
  // First half: inverse perfect shuffle (evens to lower half of the block);
  // second half mirrors it with a perfect shuffle.
  function automatic int route_dst(input int size, input int s, input int p);
    int log_n;
    int blk;
    int off;
    int base;
    log_n = $clog2(size);
    if (s < log_n - 1) blk = size >> s;
    else               blk = size >> (2 * log_n - 3 - s);
    off  = p % blk;
    base = p - off;
    if (s < log_n - 1)
      return base + ((off % 2 == 0) ? off / 2 : blk / 2 + off / 2);
    else
      return base + ((off < blk / 2) ? 2 * off : 2 * (off - blk / 2) + 1);
  endfunction

endpackage

// File: rtl/benes_stage.sv
// One Benes column: SIZE/2 two-by-two switches feeding a stall-gated register
// that carries the beat payload plus its valid, bank ID and bypass flag.
module benes_stage
  import benes_pkg::*;
#(
  parameter int SIZE       = DEF_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              stall,
  input  logic                              in_valid,
  input  bank_id_t                          in_bank,
  input  logic                              in_byp,
  input  logic [SIZE/2-1:0]                 ctrl,
  input  logic [SIZE-1:0][DATA_WIDTH-1:0]   in_data,
  output logic                              out_valid,
  output bank_id_t                          out_bank,
  output logic                              out_byp,
  output logic [SIZE-1:0][DATA_WIDTH-1:0]   out_data
);

  logic [SIZE-1:0][DATA_WIDTH-1:0] sw_data;

  for (genvar k = 0; k < SIZE / 2; k++) begin : g_switch
    assign sw_data[2*k]   = ctrl[k] ? in_data[2*k+1] : in_data[2*k];
    assign sw_data[2*k+1] = ctrl[k] ? in_data[2*k]   : in_data[2*k+1];
  end

  // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_bank  <= '0;
      out_byp   <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      out_bank  <= in_bank;
      out_byp   <= in_byp;
    end
  end

  // NOTE: wide payload is deliberately not reset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (!stall) out_data <= sw_data;
  end

endmodule

// File: rtl/benes_pipe_network.sv
// Pipelined SIZE-port Benes network, one register per stage, with double-banked
// per-beat switch configuration. Optional per-beat bypass: define BENES_BYPASS_EN.
module benes_pipe_network
  import benes_pkg::*;
#(
  parameter int SIZE       = DEF_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_valid,
  output logic                                   o_in_ready,
  input  logic [SIZE-1:0][DATA_WIDTH-1:0]        i_port,
`ifdef BENES_BYPASS_EN
  input  logic                                   i_bypass,
`endif
  output logic                                   o_valid,
  input  logic                                   i_out_ready,
  output logic [SIZE-1:0][DATA_WIDTH-1:0]        o_port,
  input  logic                                   cfg_we,
  input  logic [$clog2(2*$clog2(SIZE)-1)-1:0]    cfg_stage,
  input  logic [SIZE/2-1:0]                      cfg_bits,
  input  logic                                   cfg_commit,
  output logic                                   o_cfg_ready
);

  localparam int LOG_N      = $clog2(SIZE);
  localparam int STAGE_NUM  = 2 * LOG_N - 1;
  localparam int SWITCH_NUM = SIZE / 2;
  localparam int STG_W      = $clog2(STAGE_NUM);
  localparam int CNT_W      = $clog2(STAGE_NUM + 1);
  localparam int LAST       = STAGE_NUM - 1;

  typedef logic [SIZE-1:0][DATA_WIDTH-1:0] beat_t;

  beat_t                 din     [STAGE_NUM];
  beat_t                 dout    [STAGE_NUM];
  logic                  v_in    [STAGE_NUM];
  logic                  v_q     [STAGE_NUM];
  logic                  byp_in  [STAGE_NUM];
  logic                  byp_q   [STAGE_NUM];
  bank_id_t              bank_in [STAGE_NUM];
  bank_id_t              bank_q  [STAGE_NUM];
  logic [SWITCH_NUM-1:0] ctrl    [STAGE_NUM];

  logic [SWITCH_NUM-1:0] cfg_mem  [2][STAGE_NUM];
  logic [CNT_W-1:0]      inflight [2];
  bank_id_t              active_bank;
  bank_id_t              shadow_bank;
  logic                  stall;
  logic                  accept;
  logic                  bypass_in;
  logic                  inc_en;
  logic                  dec_en;

`ifdef BENES_BYPASS_EN
  assign bypass_in = i_bypass;
`else
  assign bypass_in = 1'b0;
`endif

  assign stall       = o_valid && !i_out_ready;
  assign o_in_ready  = !stall;
  assign accept      = i_valid && o_in_ready;
  assign shadow_bank = ~active_bank;
  assign o_cfg_ready = (inflight[shadow_bank] == '0);
  assign o_valid     = v_q[LAST];
  assign o_port      = dout[LAST];

  for (genvar s = 0; s < STAGE_NUM; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign v_in[s]    = i_valid;
      assign bank_in[s] = active_bank;
      assign byp_in[s]  = bypass_in;
      assign din[s]     = i_port;
    end else begin : g_rest
      assign v_in[s]    = v_q[s-1];
      assign bank_in[s] = bank_q[s-1];
      assign byp_in[s]  = byp_q[s-1];
      for (genvar p = 0; p < SIZE; p++) begin : g_wire
        localparam int DST = route_dst(SIZE, s - 1, p);
        assign din[s][DST] = dout[s-1][p];
      end
    end

    // Each beat is steered by the row of the bank it was accepted under.
    assign ctrl[s] = byp_in[s] ? '0 : cfg_mem[bank_in[s]][s];

    benes_stage #(
      .SIZE       (SIZE),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (stall),
      .in_valid  (v_in[s]),
      .in_bank   (bank_in[s]),
      .in_byp    (byp_in[s]),
      .ctrl      (ctrl[s]),
      .in_data   (din[s]),
      .out_valid (v_q[s]),
      .out_bank  (bank_q[s]),
      .out_byp   (byp_q[s]),
      .out_data  (dout[s])
    );
  end

  // Banks reset to all-straight; a write in the commit cycle lands in the
  // bank that is about to become active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_bank <= '0;
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < STAGE_NUM; s++)
          cfg_mem[b][s] <= '0;
    end else begin
      if (cfg_we && o_cfg_ready && (cfg_stage < STG_W'(STAGE_NUM)))
        cfg_mem[shadow_bank][cfg_stage] <= cfg_bits;
      if (cfg_commit)
        active_bank <= ~active_bank;
    end
  end

  assign inc_en = accept && !bypass_in;
  assign dec_en = o_valid && i_out_ready && !byp_q[LAST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight[0] <= '0;
      inflight[1] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        case ({inc_en && (active_bank == bank_id_t'(b)),
               dec_en && (bank_q[LAST] == bank_id_t'(b))})
          2'b10:   inflight[b] <= inflight[b] + CNT_W'(1);
          2'b01:   inflight[b] <= inflight[b] - CNT_W'(1);
          default: inflight[b] <= inflight[b];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_benes_pipe_network.sv
// Self-checking bench for benes_pipe_network at SIZE=8: directed table, stall,
// reset and bank-swap sequences, then random traffic against a reference model.
module tb_benes_pipe_network;

  localparam int SIZE      = 8;
  localparam int DW        = 16;
  localparam int LOG_N     = 3;
  localparam int STAGE_NUM = 5;
  localparam int SW        = SIZE / 2;

  typedef logic [SIZE-1:0][DW-1:0] port_t;
  typedef struct {
    port_t data;
    logic  bank;
    logic  byp;
  } beat_t;
  typedef struct {
    logic [STAGE_NUM-1:0][SW-1:0] rows;
    logic [SIZE-1:0][2:0]         idx;   // out[q] = in[idx[q]]
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic          o_in_ready;
  port_t         i_port;
  logic          o_valid;
  logic          i_out_ready;
  port_t         o_port;
  logic          cfg_we;
  logic [2:0]    cfg_stage;
  logic [SW-1:0] cfg_bits;
  logic          cfg_commit;
  logic          o_cfg_ready;
`ifdef BENES_BYPASS_EN
  logic          i_bypass;
`endif

  int            n_vec = 0;
  int            n_err = 0;
  logic [SW-1:0] m_cfg [2][STAGE_NUM];
  logic          m_active;
  beat_t         sb [$];
  logic          acc;
  logic          got_out;
  port_t         last_out;
  int            popped = 0;

  always #5 clk = ~clk;

  benes_pipe_network #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (i_valid),
    .o_in_ready  (o_in_ready),
    .i_port      (i_port),
`ifdef BENES_BYPASS_EN
    .i_bypass    (i_bypass),
`endif
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready),
    .o_port      (o_port),
    .cfg_we      (cfg_we),
    .cfg_stage   (cfg_stage),
    .cfg_bits    (cfg_bits),
    .cfg_commit  (cfg_commit),
    .o_cfg_ready (o_cfg_ready)
  );

  task automatic check(input string name, input logic [SIZE*DW-1:0] act,
                       input logic [SIZE*DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Follow every input port through the network: switch, then rotate the
  // offset bits inside the block (right for inverse shuffle, left for shuffle).
  function automatic port_t model_route(input port_t din, input logic b);
    port_t dout;
    int pos, m, blk, o, base;
    dout = '0;
    for (int p = 0; p < SIZE; p++) begin
      pos = p;
      for (int s = 0; s < STAGE_NUM; s++) begin
        if (m_cfg[b][s][pos/2]) pos = pos ^ 1;
        if (s < STAGE_NUM - 1) begin
          m    = (s < LOG_N - 1) ? LOG_N - s : LOG_N - (STAGE_NUM - 2 - s);
          blk  = 1 << m;
          o    = pos % blk;
          base = pos - o;
          if (s < LOG_N - 1) o = (o >> 1) | ((o & 1) << (m - 1));
          else               o = ((o << 1) & (blk - 1)) | (o >> (m - 1));
          pos = base + o;
        end
      end
      dout[pos] = din[p];
    end
    return dout;
  endfunction

  function automatic port_t rand_port();
    port_t d;
    for (int p = 0; p < SIZE; p++) d[p] = DW'($urandom);
    return d;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_active = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int s = 0; s < STAGE_NUM; s++) m_cfg[b][s] = '0;
  endtask

  // One clock: inputs were driven at the falling edge; observe, update the
  // model with what the coming rising edge will do, then move to the next fall.
  task automatic tick();
    logic  exp_rdy;
    logic  cur_byp;
    beat_t e;
    #1;
    acc = 1'b0;
`ifdef BENES_BYPASS_EN
    cur_byp = i_bypass;
`else
    cur_byp = 1'b0;
`endif
    exp_rdy = 1'b1;
    foreach (sb[i]) if (!sb[i].byp && sb[i].bank == !m_active) exp_rdy = 1'b0;
    check("cfg_ready", o_cfg_ready, exp_rdy);
    if (o_valid) begin
      if (sb.size() == 0) check("spurious_valid", o_valid, 0);
      else if (i_out_ready) begin
        e = sb.pop_front();
        check("o_port", o_port, e.data);
        got_out  = 1'b1;
        last_out = o_port;
        popped++;
      end
    end
    if (i_valid && o_in_ready) begin
      e.data = cur_byp ? i_port : model_route(i_port, m_active);
      e.bank = m_active;
      e.byp  = cur_byp;
      sb.push_back(e);
      acc = 1'b1;
    end
    if (cfg_we && exp_rdy && cfg_stage < STAGE_NUM) m_cfg[!m_active][cfg_stage] = cfg_bits;
    if (cfg_commit) m_active = !m_active;
    @(negedge clk);
  endtask

  task automatic write_row(input int st, input logic [SW-1:0] bits);
    cfg_we = 1'b1; cfg_stage = 3'(st); cfg_bits = bits;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int t = 0;
    while (sb.size() > 0 && t < max) begin tick(); t++; end
    check("drain", sb.size(), 0);
  endtask

  task automatic run_beat(input port_t d, output port_t q, output int lat);
    i_port = d; i_valid = 1'b1;
    tick();
    check("beat_accept", acc, 1);
    i_valid = 1'b0; got_out = 1'b0; lat = 0;
    while (!got_out && lat < 20) begin tick(); lat++; end
    check("beat_out", got_out, 1);
    q = last_out;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t  tbl [4];
    port_t d, q, ramp, exp;
    int    lat, n, cyc, pop0, beats;

    for (int i = 0; i < 4; i++) tbl[i].rows = '0;
    tbl[1].rows = {STAGE_NUM{4'hF}};
    tbl[2].rows = {4'h0, 4'h0, 4'hF, 4'hF, 4'hF};
    tbl[3].rows = {4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int qq = 0; qq < SIZE; qq++) begin
      tbl[0].idx[qq] = 3'(qq);
      tbl[1].idx[qq] = 3'(qq ^ 4);
      tbl[2].idx[qq] = 3'(7 - qq);
      tbl[3].idx[qq] = (qq < 2) ? 3'(qq ^ 1) : 3'(qq);
    end
    for (int p = 0; p < SIZE; p++) ramp[p] = DW'(p * 16'h1111);

    rst_n = 1'b0; i_valid = 1'b0; i_out_ready = 1'b1; i_port = '0;
    cfg_we = 1'b0; cfg_stage = '0; cfg_bits = '0; cfg_commit = 1'b0;
`ifdef BENES_BYPASS_EN
    i_bypass = 1'b0;
`endif
    model_reset();
    got_out = 1'b0; last_out = '0; acc = 1'b0;

    // Reset state and first cycle after release.
    @(negedge clk); #1;
    check("reset_o_valid", o_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", o_in_ready, 1);
    check("post_reset_cfg_ready", o_cfg_ready, 1);
    tick();

    // Directed table: program shadow, commit, route one beat, check latency.
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < STAGE_NUM; s++) write_row(s, tbl[i].rows[s]);
      write_row(7, 4'hF);
      commit();
      d = rand_port();
      run_beat(d, q, lat);
      for (int qq = 0; qq < SIZE; qq++) exp[qq] = d[tbl[i].idx[qq]];
      check($sformatf("table%0d_port", i), q, exp);
      check($sformatf("table%0d_latency", i), lat, STAGE_NUM);
    end

    // Stream 10 beats with a 4-cycle downstream stall.
    pop0 = popped; n = 0; cyc = 0;
    d = rand_port();
    while (n < 10 && cyc < 200) begin
      i_port = d; i_valid = 1'b1;
      i_out_ready = (cyc >= 7 && cyc < 11) ? 1'b0 : 1'b1;
      #1;
      if (!i_out_ready) begin
        check("stall_o_valid", o_valid, 1);
        check("stall_in_ready", o_in_ready, 0);
      end
      tick();
      if (acc) begin n++; d = rand_port(); end
      cyc++;
    end
    i_valid = 1'b0; i_out_ready = 1'b1;
    wait_drain(50);
    check("stall_beat_count", popped - pop0, 10);

    // Reset with 4 beats stuck in the pipe.
    i_out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      i_port = rand_port(); i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    tick(); tick();
    #1;
    check("pre_reset_o_valid", o_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_o_valid", o_valid, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1; i_out_ready = 1'b1;
    #1;
    check("rerelease_in_ready", o_in_ready, 1);
    check("rerelease_cfg_ready", o_cfg_ready, 1);
    repeat (12) tick();

    // Bank swap with 3 bank-0 beats in flight; bank 1 holds a reversal.
    write_row(0, 4'hF); write_row(1, 4'hF); write_row(2, 4'hF);
    write_row(3, 4'h0); write_row(4, 4'h0);
    for (int j = 0; j < 3; j++) begin
      i_port = rand_port(); i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    commit();
    #1;
    check("swap_cfg_ready_busy", o_cfg_ready, 0);
    write_row(0, 4'h5);
    for (int j = 0; j < 3; j++) begin
      i_port = rand_port(); i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    wait_drain(40);
    #1;
    check("swap_cfg_ready_idle", o_cfg_ready, 1);
    run_beat(ramp, q, lat);
    for (int qq = 0; qq < SIZE; qq++) exp[qq] = ramp[SIZE-1-qq];
    check("swap_reversed", q, exp);
    commit();
    run_beat(ramp, q, lat);
    check("swap_back_identity", q, ramp);

`ifdef BENES_BYPASS_EN
    // Bypass beat under a reversing bank leaves counters untouched.
    commit();
    got_out = 1'b0;
    i_port = ramp; i_valid = 1'b1; i_bypass = 1'b1;
    tick();
    i_valid = 1'b0; i_bypass = 1'b0;
    commit();
    #1;
    check("bypass_cfg_ready", o_cfg_ready, 1);
    n = 0;
    while (!got_out && n < 20) begin tick(); n++; end
    check("bypass_identity", last_out, ramp);
`endif

    // Random traffic, random config writes and commits.
    beats = 0; cyc = 0;
    while (beats < 1000 && cyc < 20000) begin
      i_valid     = ($urandom % 4) != 0;
      i_port      = rand_port();
      i_out_ready = ($urandom % 4) != 0;
      cfg_we      = ($urandom % 6) == 0;
      cfg_stage   = 3'($urandom % 8);
      cfg_bits    = SW'($urandom);
      cfg_commit  = ($urandom % 24) == 0;
      tick();
      if (acc) beats++;
      cyc++;
    end
    i_valid = 1'b0; i_out_ready = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0;
    check("random_beats", beats, 1000);
    wait_drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
